// File: rtl/pe_pkg.sv
// Shared definitions for the PE array: operand/result widths and the operand-feeder FSM states.
package pe_pkg;

   localparam int unsigned OPA_W = 8;
   localparam int unsigned OPB_W = 8;
   localparam int unsigned ACC_W = 20;

   typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, OUT} feeder_state_e;

endpackage

// File: rtl/pe_operand_feeder_if.sv
// Bundle of job, operand-stream, PE-side and result signals around one operand feeder.
interface pe_operand_feeder_if
   import pe_pkg::*;
#(
   parameter int unsigned CNT_W = 9,
   parameter int unsigned ACC_W = pe_pkg::ACC_W
);

   logic             job_valid;
   logic             job_ready;
   logic [CNT_W-1:0] job_len;
   logic             job_relu;
   logic             act_valid;
   logic             act_ready;
   logic [OPA_W-1:0] act_data;
   logic             wgt_valid;
   logic             wgt_ready;
   logic [OPB_W-1:0] wgt_data;
   logic             pe_en;
   logic             mode_sel;
   logic             reg_reset;
   logic [OPA_W-1:0] a_mul;
   logic [OPB_W-1:0] b_mul;
   logic [ACC_W-1:0] pe_result;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;

   modport master (
      input  job_valid, job_len, job_relu, act_valid, act_data, wgt_valid, wgt_data,
             pe_result, res_ready,
      output job_ready, act_ready, wgt_ready, pe_en, mode_sel, reg_reset, a_mul, b_mul,
             res_valid, res_data
   );

   modport slave (
      output job_valid, job_len, job_relu, act_valid, act_data, wgt_valid, wgt_data,
             pe_result, res_ready,
      input  job_ready, act_ready, wgt_ready, pe_en, mode_sel, reg_reset, a_mul, b_mul,
             res_valid, res_data
   );

endinterface

// File: rtl/pe_operand_feeder.sv
// Sequences one dot-product job into a pe_core: clears it, streams operand pairs, waits for
// the PE pipeline to drain and then holds the captured result on a valid/ready port.
module pe_operand_feeder
   import pe_pkg::*;
#(
   parameter int unsigned K_MAX  = 256,
   parameter int unsigned CNT_W  = $clog2(K_MAX + 1),
   parameter int unsigned PE_LAT = 2
) (
   input logic                clk,
   input logic                reset_n,
   pe_operand_feeder_if.master bus
);

   localparam logic [CNT_W-1:0] KMax    = CNT_W'(K_MAX);
   localparam int unsigned      DRN_W   = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);
   localparam logic [DRN_W-1:0] DrnLast = DRN_W'(PE_LAT);

   feeder_state_e    state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [DRN_W-1:0] drn_q, drn_d;
   logic             job_ready_q, job_ready_d;
   logic             pe_en_q, pe_en_d;
   logic             reg_reset_q, reg_reset_d;
   logic             mode_q, mode_d;
   logic [OPA_W-1:0] a_q, a_d;
   logic [OPB_W-1:0] b_q, b_d;
   logic             res_valid_q, res_valid_d;
   logic [ACC_W-1:0] res_data_q, res_data_d;
   logic             fire;

   // Joined handshake: each side is told "ready" only when the other side has data.
   assign fire    = (state_q == FEED) && bus.act_valid && bus.wgt_valid;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      drn_d       = drn_q;
      pe_en_d     = 1'b0;
      reg_reset_d = 1'b0;
      mode_d      = mode_q;
      a_d         = a_q;
      b_d         = b_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      case (state_q)
         IDLE: begin
            if (job_ready_q && bus.job_valid) begin
               if (bus.job_len == '0) begin
                  res_data_d  = '0;
                  res_valid_d = 1'b1;
                  state_d     = OUT;
               end else begin
                  len_d       = (bus.job_len > KMax) ? KMax : bus.job_len;
                  mode_d      = bus.job_relu;
                  reg_reset_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = CLR;
               end
            end
         end
         CLR: state_d = FEED;
         FEED: begin
            if (fire) begin
               pe_en_d = 1'b1;
               a_d     = bus.act_data;
               b_d     = bus.wgt_data;
               cnt_d   = cnt_inc;
               if (cnt_inc == len_q) begin
                  drn_d   = '0;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Count starts in the cycle the last pe_en is high.
            drn_d = drn_q + 1'b1;
            if (drn_q == DrnLast) begin
               res_data_d  = bus.pe_result;
               res_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      job_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         drn_q       <= '0;
         job_ready_q <= 1'b0;
         pe_en_q     <= 1'b0;
         reg_reset_q <= 1'b0;
         mode_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         drn_q       <= drn_d;
         job_ready_q <= job_ready_d;
         pe_en_q     <= pe_en_d;
         reg_reset_q <= reg_reset_d;
         mode_q      <= mode_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.job_ready = job_ready_q;
   assign bus.act_ready = (state_q == FEED) && bus.wgt_valid;
   assign bus.wgt_ready = (state_q == FEED) && bus.act_valid;
   assign bus.pe_en     = pe_en_q;
   assign bus.reg_reset = reg_reset_q;
   assign bus.mode_sel  = mode_q;
   assign bus.a_mul     = a_q;
   assign bus.b_mul     = b_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder with a behavioural two-cycle-latency PE model.
module tb_pe_operand_feeder;

   localparam int unsigned K_MAX  = 4;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned ACC_W  = 20;
   localparam int unsigned PE_LAT = 2;

   typedef struct {
      logic [2:0]       len;
      bit               relu;
      logic [3:0][7:0]  act;
      logic [3:0][7:0]  wgt;
      logic [15:0]      act_stall;
      logic [15:0]      wgt_stall;
      int               hold;
      bit               b2b;
      int               exp_res;
      int               exp_pe;
      int               exp_rr;
      int               exp_cyc;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   pe_operand_feeder_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();

   pe_operand_feeder #(
      .K_MAX (K_MAX),
      .CNT_W (CNT_W),
      .PE_LAT(PE_LAT)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // PE model: accumulator plus one extra pipeline stage, ReLU on the output.
   logic signed [ACC_W-1:0] acc, dly, prod;
   assign prod = 20'($signed({1'b0, bus.a_mul})) * 20'($signed(bus.b_mul));
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
         dly <= '0;
      end else begin
         if (bus.reg_reset)  acc <= '0;
         else if (bus.pe_en) acc <= acc + prod;
         dly <= acc;
      end
   end
   assign bus.pe_result = (bus.mode_sel && dly[ACC_W-1]) ? '0 : dly;

   task automatic check_eq(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_flags"}, int'({bus.job_ready, bus.act_ready, bus.wgt_ready, bus.pe_en,
                                      bus.mode_sel, bus.reg_reset, bus.res_valid}), 0);
      check_eq({tag, "_ops"}, int'({bus.a_mul, bus.b_mul}), 0);
      check_eq({tag, "_res"}, int'(bus.res_data), 0);
   endtask

   function automatic vec_t mk(input logic [2:0] len, input bit relu, input logic [31:0] act,
                               input logic [31:0] wgt, input logic [15:0] ast,
                               input logic [15:0] wst, input int hold, input bit b2b,
                               input int res, input int pe, input int rr, input int cyc);
      vec_t v;
      v.len = len; v.relu = relu; v.act = act; v.wgt = wgt;
      v.act_stall = ast; v.wgt_stall = wst; v.hold = hold; v.b2b = b2b;
      v.exp_res = res; v.exp_pe = pe; v.exp_rr = rr; v.exp_cyc = cyc;
      return v;
   endfunction

   // Called and returns at a negedge. Cycle 0 is the cycle in which the job is accepted.
   task automatic run_job(input string tag, input vec_t v, input bit chain, input vec_t nxt);
      int c, ai, wi, pe_n, rr_n, first_rr, first_pe, res_c, waitc, mode_err, hold_err;
      bit done, fa, fw;
      logic [ACC_W-1:0] held;
      ai = 0; wi = 0; pe_n = 0; rr_n = 0; first_rr = -1; first_pe = -1; res_c = -1;
      waitc = 0; mode_err = 0; hold_err = 0; done = 1'b0;
      bus.job_len   = v.len;
      bus.job_relu  = v.relu;
      bus.job_valid = 1'b1;
      bus.res_ready = (v.hold == 0);
      #1;
      while (!bus.job_ready && waitc < 20) begin
         @(negedge clk);
         #1;
         waitc++;
      end
      if (v.b2b) check_eq({tag, "_b2b_ready_wait"}, waitc, 0);
      @(posedge clk);
      @(negedge clk);
      bus.job_valid = 1'b0;
      c = 1;
      while (!done && c < 60) begin
         bus.act_valid = (ai < v.exp_pe) && !(c < 16 && v.act_stall[c]);
         bus.wgt_valid = (wi < v.exp_pe) && !(c < 16 && v.wgt_stall[c]);
         bus.act_data  = (ai < 4) ? v.act[ai] : 8'h00;
         bus.wgt_data  = (wi < 4) ? v.wgt[wi] : 8'h00;
         #1;
         if (bus.reg_reset) begin
            rr_n++;
            if (first_rr < 0) first_rr = c;
         end
         if (bus.pe_en) begin
            pe_n++;
            if (first_pe < 0) first_pe = c;
            if (bus.mode_sel !== v.relu) mode_err++;
         end
         fa = bus.act_valid && bus.act_ready;
         fw = bus.wgt_valid && bus.wgt_ready;
         if (bus.res_valid) begin
            done  = 1'b1;
            res_c = c;
            held  = bus.res_data;
            check_eq({tag, "_res_data"}, int'($signed(bus.res_data)), v.exp_res);
            if (v.hold > 0) begin
               if (chain) begin
                  bus.job_len   = nxt.len;
                  bus.job_relu  = nxt.relu;
                  bus.job_valid = 1'b1;
               end
               for (int h = 0; h < v.hold; h++) begin
                  if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.job_ready !== 1'b0)
                     hold_err++;
                  @(posedge clk);
                  @(negedge clk);
                  #1;
               end
               check_eq({tag, "_hold_stable_errs"}, hold_err, 0);
               bus.res_ready = 1'b1;
            end
         end
         @(posedge clk);
         if (fa) ai++;
         if (fw) wi++;
         @(negedge clk);
         c++;
      end
      bus.act_valid = 1'b0;
      bus.wgt_valid = 1'b0;
      check_eq({tag, "_done"}, int'(done), 1);
      check_eq({tag, "_res_cycle"}, res_c, v.exp_cyc);
      check_eq({tag, "_pe_en_pulses"}, pe_n, v.exp_pe);
      check_eq({tag, "_pairs_consumed"}, ai + wi, 2 * v.exp_pe);
      check_eq({tag, "_reg_reset_pulses"}, rr_n, v.exp_rr);
      if (v.exp_rr > 0) check_eq({tag, "_reg_reset_cycle"}, first_rr, 1);
      if (v.exp_pe > 0) check_eq({tag, "_first_pe_cycle"}, first_pe, 3);
      check_eq({tag, "_mode_sel_errs"}, mode_err, 0);
   endtask

   vec_t vecs[7];
   vec_t post;

   initial begin
      int n;
      bus.job_valid = 1'b0; bus.job_len = '0; bus.job_relu = 1'b0;
      bus.act_valid = 1'b0; bus.act_data = '0;
      bus.wgt_valid = 1'b0; bus.wgt_data = '0;
      bus.res_ready = 1'b1;

      //         len  relu act           wgt           ast      wst      hold b2b res  pe rr cyc
      vecs[0] = mk(3, 0, 32'h00030201, 32'h0006FB04, 16'h0000, 16'h0000, 0, 0, 12, 3, 1, 8);
      vecs[1] = mk(3, 1, 32'h00030201, 32'h00FAFBFC, 16'h0000, 16'h0000, 0, 0, 0, 3, 1, 8);
      vecs[2] = mk(4, 0, 32'h02020202, 32'h03030303, 16'h0018, 16'h0040, 0, 0, 24, 4, 1, 12);
      vecs[3] = mk(0, 0, 32'h00000000, 32'h00000000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1);
      vecs[4] = mk(5, 0, 32'h01010101, 32'h01010101, 16'h0000, 16'h0000, 0, 0, 4, 4, 1, 9);
      vecs[5] = mk(2, 0, 32'h00000403, 32'h0000FF05, 16'h0000, 16'h0000, 5, 0, 11, 2, 1, 7);
      vecs[6] = mk(1, 0, 32'h00000002, 32'h00000003, 16'h0000, 16'h0000, 0, 1, 6, 1, 1, 6);
      post    = mk(2, 0, 32'h00000107, 32'h00000101, 16'h0000, 16'h0000, 0, 0, 8, 2, 1, 7);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_job($sformatf("v%0d", i), vecs[i], (i == 5), vecs[(i + 1) % 7]);

      // Mid-job reset: a 4-pair ReLU job is aborted after two pairs.
      bus.job_len = 3'd5; bus.job_relu = 1'b1; bus.job_valid = 1'b1;
      bus.act_valid = 1'b1; bus.act_data = 8'd9;
      bus.wgt_valid = 1'b1; bus.wgt_data = 8'd9;
      n = 0;
      for (int k = 0; k < 20 && n < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         bus.job_valid = 1'b0;
         #1;
         if (bus.pe_en) n++;
      end
      check_eq("midrst_pairs_before_reset", n, 2);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      bus.act_valid = 1'b0;
      bus.wgt_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_job("post_rst", post, 1'b0, post);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
Operand sequencer that drives one pe_core and collects its result. It accepts a dot-product job of length N and clears the PE accumulator. It then streams N (activation, weight) pairs from two valid/ready buffer read streams into the PE's a_mul/b_mul/pe_en inputs. After the PE pipeline drains, it captures the accumulated result and presents it on a valid/ready result port. It sits between the activation/weight buffers and each PE in the array.

Parameters:
K_MAX, 256, maximum job length (pairs per dot product)
CNT_W, $clog2(K_MAX+1), width of job length and pair counter
ACC_W, 20, width of the PE result
PE_LAT, 2, cycles from the PE sampling its last pe_en to pe_result holding the final value

Ports:
clk  in  1  work clock
reset_n  in  1  asynchronous reset, active low
job_valid  in  1  job request
job_ready  out  1  feeder can accept a job
job_len  in  CNT_W  number of pairs N; values above K_MAX are clamped to K_MAX
job_relu  in  1  0: raw result; 1: ReLU result
act_valid  in  1  activation available
act_ready  out  1  activation consumed
act_data  in  8  activation, unsigned
wgt_valid  in  1  weight available
wgt_ready  out  1  weight consumed
wgt_data  in  8  weight, signed
pe_en  out  1  PE multiply/accumulate enable
mode_sel  out  1  PE mode, latched from job_relu
reg_reset  out  1  PE accumulator clear
a_mul  out  8  PE operand 1, unsigned
b_mul  out  8  PE operand 2, signed
pe_result  in  ACC_W  PE accumulated result, signed
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  ACC_W  captured result, signed

Behaviour:
- Reset (async, reset_n=0): state IDLE, counters 0, all outputs 0. A reset in any state aborts the job; no partial result is emitted and no stream handshake is counted.
- All PE-side outputs (pe_en, reg_reset, a_mul, b_mul, mode_sel) and res_data/res_valid are registered.
- FSM states: IDLE, CLR, FEED, DRAIN, OUT.
- IDLE: job_ready=1.
  - On job_valid with N>=1: latch min(job_len, K_MAX) and job_relu; go to CLR.
  - On job_valid with job_len=0: load res_data=0 and go to OUT; the PE is untouched.
- CLR: reg_reset=1 for exactly one cycle; mode_sel already holds the latched job_relu. Go to FEED.
- FEED:
  - Joined handshake: act_ready=wgt_valid and wgt_ready=act_valid, so a pair fires only when both valids are high.
  - On fire: next cycle pe_en=1, a_mul=act_data, b_mul=wgt_data; the pair counter increments.
  - No fire: next cycle pe_en=0 (bubble); a_mul/b_mul hold.
  - When the N-th pair fires, go to DRAIN. act_ready/wgt_ready are 0 outside FEED.
- DRAIN: pe_en=0. The drain counter counts PE_LAT cycles after the cycle in which the last pe_en was high. On the final count, res_data<=pe_result; go to OUT.
- OUT: res_valid=1 and res_data stable until res_ready=1. Then res_valid=0 next cycle and state returns to IDLE.
- Latency with no stalls:
  - Job accepted at cycle 0; reg_reset high at cycle 1.
  - pe_en high at cycles 3..N+2.
  - res_valid high from cycle N+3+PE_LAT.
- Back-to-back jobs have one IDLE cycle between res_ready and the next job_ready.
- mode_sel holds its value from job latch until the next job is latched. ReLU is applied inside the PE; the feeder never modifies the result.
- Simultaneous events:
  - job_valid while not IDLE: ignored (job_ready=0).
  - Input valids dropping mid-job: stall only, the count is preserved.

Decomposition:
- Shared package pe_pkg holds OPA_W=8, OPB_W=8, ACC_W, and typedef enum feeder_state_e {IDLE, CLR, FEED, DRAIN, OUT}.
- No sub-module. The pair counter and drain counter are local. The testbench instantiates a behavioural PE model with latency PE_LAT.

Test Plan:
- Basic job: N=3, relu=0, act={1,2,3}, wgt={4,-5,6}, streams always valid, res_ready=1 -> reg_reset at cycle 1, pe_en at cycles 3..5, res_valid at cycle 8 with res_data=12.
- ReLU job: N=3, relu=1, act={1,2,3}, wgt={-4,-5,-6} -> mode_sel=1 throughout, res_data=0 (raw value would be -32).
- Stalls: N=4, all act=2, all wgt=3, with act_valid low at cycles 3-4 and wgt_valid low at cycle 6 -> pe_en pulses exactly 4 times, no pair is lost or duplicated, res_data=24.
- Zero-length and clamped jobs: job_len=0 -> res_valid next cycle with res_data=0 and no reg_reset/pe_en. job_len=K_MAX+1 (at K_MAX=4) -> exactly 4 pe_en pulses.
- Result backpressure plus back-to-back: hold res_ready=0 for 5 cycles -> res_data stable, job_ready=0. A second job_valid held high is accepted one cycle after res_ready.
- Mid-job reset: assert reset_n=0 after 2 of 5 pairs -> all outputs 0 immediately. A new job with N=2, act={7,1}, wgt={1,1} -> res_data=8.
